seq_divider_32b: RTL and testbench

Multi-cycle signed integer divider for the Mini SRC datapath. It supplies the DIV result that the ALU places on its 64-bit Z output, replacing the single-cycle `x / y`, `x % y` operators. It computes quotient and remainder by restoring division on operand magnitudes, one quotient bit per clock, then applies sign correction. It presents a start/busy/done handshake to the control unit and exposes a packed 64-bit result laid out as {remainder, quotient} for direct loading into HI/LO via Z.

---
 rtl/seq_divider_32b.sv | 166 ++++++++++++++++
 tb/tb_seq_divider_32b.sv | 357 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/seq_divider_32b.sv
// Multi-cycle signed restoring divider: one quotient bit per clock on operand
// magnitudes, then a single sign-fix edge; result packs {remainder, quotient}.
//
// Ports:
//   clk, resetn            clock, asynchronous active-low reset
//   start                  request; accepted only while idle
//   dividend, divisor      signed operands, captured on the accepting edge
//   busy                   high from the accepting edge until the result edge
//   done                   one-cycle pulse, result valid
//   div_by_zero            divisor was zero; held with the result
//   quotient, remainder    signed results (truncating division)
//   result                 {remainder, quotient}
module seq_divider_32b #(
    parameter int WIDTH = 32
) (
    input  logic               clk,
    input  logic               resetn,
    input  logic               start,
    input  logic [WIDTH-1:0]   dividend,
    input  logic [WIDTH-1:0]   divisor,
    output logic               busy,
    output logic               done,
    output logic               div_by_zero,
    output logic [WIDTH-1:0]   quotient,
    output logic [WIDTH-1:0]   remainder,
    output logic [2*WIDTH-1:0] result
);

    localparam int CW = $clog2(WIDTH) + 1;
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);
    localparam logic [CW-1:0] ONE  = CW'(1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ITER,
        S_FIX
    } state_t;

    state_t state;
    state_t state_d;

    logic [CW-1:0]    cnt;
    logic [WIDTH-1:0] p;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] dvsr_mag;
    logic [WIDTH-1:0] dvd_raw;
    logic             sign_q;
    logic             sign_r;
    logic             dbz;

    logic [WIDTH:0]   p_sh;
    logic [WIDTH:0]   trial;
    logic             take;
    logic [WIDTH-1:0] p_next;
    logic [WIDTH-1:0] q_fix;
    logic [WIDTH-1:0] r_fix;

    // |v|; the most negative value maps to 2^(WIDTH-1), still valid unsigned
    function automatic logic [WIDTH-1:0] mag(input logic [WIDTH-1:0] v);
        return v[WIDTH-1] ? -v : v;
    endfunction

    // Next-state logic
    always_comb begin
        state_d = state;
        case (state)
            S_IDLE: begin
                if (start) begin
                    state_d = (divisor == '0) ? S_FIX : S_ITER;
                end
            end
            S_ITER: begin
                if (cnt == LAST) begin
                    state_d = S_FIX;
                end
            end
            S_FIX: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state <= S_IDLE;
        end else begin
            state <= state_d;
        end
    end

    // Restoring step. p < divisor holds between steps, so the shifted value
    // is below 2*divisor and the WIDTH+1-bit difference keeps a valid sign.
    always_comb begin
        p_sh   = {p, a[WIDTH-1]};
        trial  = p_sh - {1'b0, dvsr_mag};
        take   = ~trial[WIDTH];
        p_next = take ? trial[WIDTH-1:0] : p_sh[WIDTH-1:0];
    end

    // Sign correction; divide-by-zero returns all ones and the raw dividend
    always_comb begin
        q_fix = sign_q ? -a : a;
        r_fix = sign_r ? -p : p;
        if (dbz) begin
            q_fix = '1;
            r_fix = dvd_raw;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            cnt         <= '0;
            p           <= '0;
            a           <= '0;
            dvsr_mag    <= '0;
            dvd_raw     <= '0;
            sign_q      <= 1'b0;
            sign_r      <= 1'b0;
            dbz         <= 1'b0;
            busy        <= 1'b0;
            done        <= 1'b0;
            div_by_zero <= 1'b0;
            quotient    <= '0;
            remainder   <= '0;
            result      <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (start) begin
                        dvd_raw     <= dividend;
                        a           <= mag(dividend);
                        dvsr_mag    <= mag(divisor);
                        sign_q      <= dividend[WIDTH-1] ^ divisor[WIDTH-1];
                        sign_r      <= dividend[WIDTH-1];
                        dbz         <= (divisor == '0);
                        p           <= '0;
                        cnt         <= '0;
                        div_by_zero <= 1'b0;
                        busy        <= 1'b1;
                    end
                end
                S_ITER: begin
                    p   <= p_next;
                    a   <= {a[WIDTH-2:0], take};
                    cnt <= cnt + ONE;
                end
                S_FIX: begin
                    quotient    <= q_fix;
                    remainder   <= r_fix;
                    result      <= {r_fix, q_fix};
                    div_by_zero <= dbz;
                    done        <= 1'b1;
                    busy        <= 1'b0;
                end
                default: begin
                    busy <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_seq_divider_32b.sv
// Directed and random checks for seq_divider_32b: latency, sign handling,
// edge values, divide-by-zero, protocol and mid-run reset.
module tb_seq_divider_32b;

    logic        clk;
    logic        resetn;
    logic        start;
    logic [31:0] dividend;
    logic [31:0] divisor;
    logic        busy;
    logic        done;
    logic        div_by_zero;
    logic [31:0] quotient;
    logic [31:0] remainder;
    logic [63:0] result;

    int checks;
    int errors;

    seq_divider_32b #(.WIDTH(32)) dut (
        .clk         (clk),
        .resetn      (resetn),
        .start       (start),
        .dividend    (dividend),
        .divisor     (divisor),
        .busy        (busy),
        .done        (done),
        .div_by_zero (div_by_zero),
        .quotient    (quotient),
        .remainder   (remainder),
        .result      (result)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Issue one division; return edges from accept to done and busy samples
    task automatic run_div(input logic [31:0] a, input logic [31:0] b,
                           output int lat, output int bcnt);
        @(negedge clk);
        start    = 1'b1;
        dividend = a;
        divisor  = b;
        @(posedge clk);
        #1;
        start = 1'b0;
        lat   = 0;
        bcnt  = busy ? 1 : 0;
        while (!done && lat < 100) begin
            @(posedge clk);
            #1;
            lat++;
            if (busy) bcnt++;
        end
    endtask

    task automatic test_reset;
        resetn   = 1'b0;
        start    = 1'b0;
        dividend = '0;
        divisor  = '0;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if ({busy, done, div_by_zero} !== 3'b000) begin
            errors++;
            $display("FAIL reset_flags got %b want 000", {busy, done, div_by_zero});
        end
        checks++;
        if (result !== 64'h0 || quotient !== 32'h0 || remainder !== 32'h0) begin
            errors++;
            $display("FAIL reset_data got %h/%h/%h want 0", result, quotient, remainder);
        end
        @(negedge clk);
        resetn = 1'b1;
    endtask

    task automatic test_basic;
        int lat, bcnt;
        run_div(32'd20, 32'd5, lat, bcnt);
        checks++;
        if (lat !== 33) begin
            errors++;
            $display("FAIL basic_latency got %0d want 33", lat);
        end
        checks++;
        if (bcnt !== 33) begin
            errors++;
            $display("FAIL basic_busy_cycles got %0d want 33", bcnt);
        end
        checks++;
        if (quotient !== 32'd4 || remainder !== 32'd0) begin
            errors++;
            $display("FAIL basic_qr got %0d r %0d want 4 r 0", quotient, remainder);
        end
        checks++;
        if (result !== 64'h00000000_00000004) begin
            errors++;
            $display("FAIL basic_result got %h want 0000000000000004", result);
        end
        @(posedge clk);
        #1;
        checks++;
        if (done !== 1'b0) begin
            errors++;
            $display("FAIL basic_done_pulse got %b want 0", done);
        end
    endtask

    task automatic test_signs;
        logic [31:0] va [4] = '{32'd7, -32'sd7, 32'd7, -32'sd7};
        logic [31:0] vb [4] = '{32'd2, 32'd2, -32'sd2, -32'sd2};
        logic [31:0] eq [4] = '{32'd3, 32'hFFFFFFFD, 32'hFFFFFFFD, 32'd3};
        logic [31:0] er [4] = '{32'd1, 32'hFFFFFFFF, 32'd1, 32'hFFFFFFFF};
        int lat, bcnt;
        for (int i = 0; i < 4; i++) begin
            run_div(va[i], vb[i], lat, bcnt);
            checks++;
            if (quotient !== eq[i] || remainder !== er[i] || result !== {er[i], eq[i]}) begin
                errors++;
                $display("FAIL sign_%0d got q %h r %h want q %h r %h",
                         i, quotient, remainder, eq[i], er[i]);
            end
        end
    endtask

    task automatic test_edges;
        logic [31:0] va [3] = '{32'h80000000, 32'h80000000, 32'd5};
        logic [31:0] vb [3] = '{32'hFFFFFFFF, 32'd1, 32'd9};
        logic [31:0] eq [3] = '{32'h80000000, 32'h80000000, 32'd0};
        logic [31:0] er [3] = '{32'd0, 32'd0, 32'd5};
        int lat, bcnt;
        for (int i = 0; i < 3; i++) begin
            run_div(va[i], vb[i], lat, bcnt);
            checks++;
            if (quotient !== eq[i] || remainder !== er[i] || div_by_zero !== 1'b0) begin
                errors++;
                $display("FAIL edge_%0d got q %h r %h dbz %b want q %h r %h dbz 0",
                         i, quotient, remainder, div_by_zero, eq[i], er[i]);
            end
        end
    endtask

    task automatic test_div_zero;
        int lat, bcnt;
        run_div(32'd123, 32'd0, lat, bcnt);
        checks++;
        if (lat !== 1) begin
            errors++;
            $display("FAIL dbz_latency got %0d want 1", lat);
        end
        checks++;
        if (quotient !== 32'hFFFFFFFF || remainder !== 32'd123 || div_by_zero !== 1'b1) begin
            errors++;
            $display("FAIL dbz_result got q %h r %0d dbz %b want q ffffffff r 123 dbz 1",
                     quotient, remainder, div_by_zero);
        end
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (div_by_zero !== 1'b1) begin
            errors++;
            $display("FAIL dbz_hold got %b want 1", div_by_zero);
        end
        run_div(32'd10, 32'd3, lat, bcnt);
        checks++;
        if (div_by_zero !== 1'b0 || quotient !== 32'd3 || remainder !== 32'd1) begin
            errors++;
            $display("FAIL dbz_clear got dbz %b q %0d r %0d want 0 3 1",
                     div_by_zero, quotient, remainder);
        end
    endtask

    task automatic test_busy_start;
        int lat;
        @(negedge clk);
        start    = 1'b1;
        dividend = 32'd20;
        divisor  = 32'd5;
        @(posedge clk);
        #1;
        start = 1'b0;
        lat   = 0;
        repeat (5) begin
            @(posedge clk);
            #1;
            lat++;
        end
        @(negedge clk);
        start    = 1'b1;
        dividend = 32'd100;
        divisor  = 32'd7;
        @(posedge clk);
        #1;
        lat++;
        start = 1'b0;
        while (!done && lat < 100) begin
            @(posedge clk);
            #1;
            lat++;
        end
        checks++;
        if (lat !== 33) begin
            errors++;
            $display("FAIL busy_start_latency got %0d want 33", lat);
        end
        checks++;
        if (quotient !== 32'd4 || remainder !== 32'd0) begin
            errors++;
            $display("FAIL busy_start_result got %0d r %0d want 4 r 0", quotient, remainder);
        end
        @(posedge clk);
        #1;
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL busy_start_queued got busy %b want 0", busy);
        end
    endtask

    task automatic test_back_to_back;
        int lat;
        @(negedge clk);
        start    = 1'b1;
        dividend = 32'd50;
        divisor  = 32'd7;
        @(posedge clk);
        #1;
        dividend = 32'd9;
        divisor  = 32'd4;
        lat = 0;
        while (!done && lat < 100) begin
            @(posedge clk);
            #1;
            lat++;
        end
        checks++;
        if (lat !== 33 || quotient !== 32'd7 || remainder !== 32'd1) begin
            errors++;
            $display("FAIL b2b_first got lat %0d q %0d r %0d want 33 7 1",
                     lat, quotient, remainder);
        end
        @(posedge clk);
        #1;
        start = 1'b0;
        checks++;
        if (busy !== 1'b1 || done !== 1'b0) begin
            errors++;
            $display("FAIL b2b_accept got busy %b done %b want 1 0", busy, done);
        end
        lat = 0;
        while (!done && lat < 100) begin
            @(posedge clk);
            #1;
            lat++;
        end
        checks++;
        if (lat !== 33 || quotient !== 32'd2 || remainder !== 32'd1) begin
            errors++;
            $display("FAIL b2b_second got lat %0d q %0d r %0d want 33 2 1",
                     lat, quotient, remainder);
        end
    endtask

    task automatic test_reset_mid;
        int lat, bcnt;
        bit seen;
        @(negedge clk);
        start    = 1'b1;
        dividend = 32'd1000;
        divisor  = 32'd3;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (10) @(posedge clk);
        #2;
        resetn = 1'b0;
        #1;
        checks++;
        if (busy !== 1'b0 || done !== 1'b0 || result !== 64'h0 || quotient !== 32'h0) begin
            errors++;
            $display("FAIL reset_mid_outputs got busy %b done %b result %h",
                     busy, done, result);
        end
        seen = 1'b0;
        repeat (4) begin
            @(posedge clk);
            #1;
            if (done) seen = 1'b1;
        end
        @(negedge clk);
        resetn = 1'b1;
        repeat (40) begin
            @(posedge clk);
            #1;
            if (done) seen = 1'b1;
        end
        checks++;
        if (seen !== 1'b0) begin
            errors++;
            $display("FAIL reset_mid_no_done got %b want 0", seen);
        end
        run_div(32'd100, 32'd7, lat, bcnt);
        checks++;
        if (lat !== 33 || quotient !== 32'd14 || remainder !== 32'd2) begin
            errors++;
            $display("FAIL reset_mid_after got lat %0d q %0d r %0d want 33 14 2",
                     lat, quotient, remainder);
        end
    endtask

    task automatic test_random;
        int lat, bcnt;
        int ai, bi, qe, re;
        for (int i = 0; i < 1000; i++) begin
            ai = int'($urandom);
            if (i % 2 == 0) begin
                bi = int'($urandom);
            end else begin
                bi = int'($urandom_range(0, 200)) - 100;
            end
            if (i % 7 == 3) ai = int'($urandom_range(0, 50)) - 25;
            if (bi == 0) bi = 1;
            if (ai == 32'sh80000000 && bi == -1) begin
                qe = ai;
                re = 0;
            end else begin
                qe = ai / bi;
                re = ai % bi;
            end
            run_div(ai, bi, lat, bcnt);
            checks++;
            if (lat !== 33 || quotient !== qe || remainder !== re) begin
                errors++;
                $display("FAIL random_%0d %0d/%0d got lat %0d q %0d r %0d want 33 q %0d r %0d",
                         i, ai, bi, lat, $signed(quotient), $signed(remainder), qe, re);
            end
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        test_reset;
        test_basic;
        test_signs;
        test_edges;
        test_div_zero;
        test_busy_start;
        test_back_to_back;
        test_reset_mid;
        test_random;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
